// File: rtl/spi_ram_target.sv
// Mode-0 SPI responder emulating the external program RAM (0x03 READ / 0x02 WRITE, 16-bit address).
// MISO updates 2 clk after a SCK fall; no backpressure, the initiator must hold SCK phases >= 2 clk.
module spi_ram_target #(
  parameter int   ADDR_BITS  = 8,
  parameter logic RESET_MISO = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_cs_n,
  input  logic                 spi_sck,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  input  logic                 ld_en,
  input  logic [ADDR_BITS-1:0] ld_addr,
  input  logic [7:0]           ld_data,
  output logic                 busy,
  output logic                 cmd_err,
  output logic [7:0]           last_cmd
);

  localparam int MEM_DEPTH = 1 << ADDR_BITS;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE} state_t;

  state_t state, state_nxt;

  logic                 cs_q, sck_q, sck_prev, mosi_q;
  logic                 sck_rise, sck_fall;
  logic [3:0]           bit_cnt;
  logic [7:0]           rx_shift, rx_next;
  logic [ADDR_BITS-1:0] addr_shift, addr_next;
  logic [ADDR_BITS-1:0] addr, addr_inc;
  logic [7:0]           tx_shift;
  logic                 cmd_done, addr_done, byte_done;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [7:0]           mem_wdata;
  logic [7:0]           mem [0:MEM_DEPTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_q     <= 1'b1;
      sck_q    <= 1'b0;
      sck_prev <= 1'b0;
      mosi_q   <= 1'b0;
    end else begin
      cs_q     <= spi_cs_n;
      sck_q    <= spi_sck;
      sck_prev <= sck_q;
      mosi_q   <= spi_mosi;
    end
  end

  assign sck_rise  = sck_q & ~sck_prev;
  assign sck_fall  = ~sck_q & sck_prev;
  // Upper shifted bits fall off the top, which gives the address aliasing.
  assign rx_next   = 8'({rx_shift, mosi_q});
  assign addr_next = ADDR_BITS'({addr_shift, mosi_q});
  assign addr_inc  = addr + ADDR_BITS'(1);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_done  = 1'b0;
    addr_done = 1'b0;
    byte_done = 1'b0;
    if (cs_q) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = CMD;
        CMD: begin
          if (sck_rise && bit_cnt == 4'd7) begin
            cmd_done  = 1'b1;
            state_nxt = ADDR;
          end
        end
        ADDR: begin
          if (sck_rise && bit_cnt == 4'd15) begin
            addr_done = 1'b1;
            case (last_cmd)
              8'h03:   state_nxt = READ;
              8'h02:   state_nxt = WRITE;
              default: state_nxt = IGNORE;
            endcase
          end
        end
        READ, WRITE: byte_done = sck_rise && (bit_cnt[2:0] == 3'd7);
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      rx_shift   <= '0;
      addr_shift <= '0;
      addr       <= '0;
      tx_shift   <= '0;
      spi_miso   <= RESET_MISO;
      cmd_err    <= 1'b0;
      last_cmd   <= 8'h00;
    end else if (cs_q) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      spi_miso <= RESET_MISO;
    end else begin
      case (state)
        CMD: begin
          if (sck_rise) begin
            rx_shift <= rx_next;
            bit_cnt  <= cmd_done ? 4'd0 : bit_cnt + 4'd1;
            if (cmd_done) last_cmd <= rx_next;
          end
        end
        ADDR: begin
          if (sck_rise) begin
            addr_shift <= addr_next;
            bit_cnt    <= addr_done ? 4'd0 : bit_cnt + 4'd1;
            if (addr_done) begin
              addr <= addr_next;
              if (last_cmd == 8'h03) tx_shift <= mem[addr_next];
              if (last_cmd != 8'h03 && last_cmd != 8'h02) cmd_err <= 1'b1;
            end
          end
        end
        READ: begin
          if (sck_fall) begin
            spi_miso <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
          if (sck_rise) begin
            bit_cnt <= byte_done ? 4'd0 : bit_cnt + 4'd1;
            if (byte_done) begin
              addr     <= addr_inc;
              tx_shift <= mem[addr_inc];
            end
          end
        end
        WRITE: begin
          if (sck_rise) begin
            rx_shift <= rx_next;
            bit_cnt  <= byte_done ? 4'd0 : bit_cnt + 4'd1;
            if (byte_done) addr <= addr_inc;
          end
        end
        default: bit_cnt <= '0;
      endcase
    end
  end

  // Single write port: SPI owns it while busy, the load port only when idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ld_addr;
    mem_wdata = ld_data;
    if (state == WRITE && byte_done && rst_n) begin
      mem_we    = 1'b1;
      mem_waddr = addr;
      mem_wdata = rx_next;
    end else if (ld_en && state == IDLE) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_spi_ram_target.sv
module tb_spi_ram_target;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = 8'h00;
  logic [7:0] ld_data = 8'h00;
  logic       busy;
  logic       cmd_err;
  logic [7:0] last_cmd;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx;

  spi_ram_target #(.ADDR_BITS(8), .RESET_MISO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(busy), .cmd_err(cmd_err), .last_cmd(last_cmd)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick(1);
    ld_en = 1'b0;
  endtask

  // Mode 0: MOSI set while SCK low, MISO sampled just before each rise.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rxb);
    rxb = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[7-i];
      tick(4);
      rxb = {rxb[6:0], spi_miso};
      spi_sck = 1'b1;
      tick(4);
      spi_sck = 1'b0;
    end
  endtask

  task automatic spi_hdr(input logic [7:0] cmd, input logic [15:0] a);
    logic [7:0] dummy;
    spi_cs_n = 1'b0;
    tick(4);
    spi_bits(cmd, 8, dummy);
    spi_bits(a[15:8], 8, dummy);
    spi_bits(a[7:0], 8, dummy);
  endtask

  task automatic spi_end();
    tick(4);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    tick(4);
  endtask

  initial begin
    tick(3);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_miso", 32'(spi_miso), 32'h0);
    chk("reset_cmd_err", 32'(cmd_err), 32'h0);
    chk("reset_last_cmd", 32'(last_cmd), 32'h00);
    rst_n = 1'b1;
    tick(2);

    // 1: preload and stream two bytes
    load(8'h00, 8'h21);
    load(8'h01, 8'h43);
    spi_hdr(8'h03, 16'h0000);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_last_cmd", 32'(last_cmd), 32'h03);
    spi_bits(8'h00, 8, rx);
    chk("t1_byte0", 32'(rx), 32'h21);
    spi_bits(8'h00, 8, rx);
    chk("t1_byte1", 32'(rx), 32'h43);
    chk("t1_cmd_err", 32'(cmd_err), 32'h0);
    spi_end();
    chk("t1_busy_after", 32'(busy), 32'h0);
    chk("t1_miso_after", 32'(spi_miso), 32'h0);

    // 2: write two bytes, read them back
    spi_hdr(8'h02, 16'h0010);
    spi_bits(8'hA5, 8, rx);
    spi_bits(8'h5A, 8, rx);
    spi_end();
    spi_hdr(8'h03, 16'h0010);
    spi_bits(8'h00, 8, rx);
    chk("t2_byte0", 32'(rx), 32'hA5);
    spi_bits(8'h00, 8, rx);
    chk("t2_byte1", 32'(rx), 32'h5A);
    spi_end();

    // 3: upper address bits alias, index wraps 0xFF -> 0x00
    load(8'hFF, 8'h11);
    load(8'h00, 8'h22);
    spi_hdr(8'h03, 16'h01FF);
    spi_bits(8'h00, 8, rx);
    chk("t3_byte0", 32'(rx), 32'h11);
    spi_bits(8'h00, 8, rx);
    chk("t3_byte1", 32'(rx), 32'h22);
    spi_end();

    // 4: unsupported command
    spi_hdr(8'h9F, 16'h0000);
    spi_bits(8'hFF, 8, rx);
    chk("t4_miso_quiet", 32'(rx), 32'h00);
    chk("t4_cmd_err", 32'(cmd_err), 32'h1);
    chk("t4_last_cmd", 32'(last_cmd), 32'h9F);
    spi_end();
    spi_hdr(8'h03, 16'h0000);
    spi_bits(8'h00, 8, rx);
    chk("t4_mem_intact", 32'(rx), 32'h22);
    chk("t4_cmd_err_sticky", 32'(cmd_err), 32'h1);
    spi_end();

    // 5: partial write byte dropped, load port gated by busy
    load(8'h06, 8'h66);
    load(8'h30, 8'h99);
    spi_hdr(8'h02, 16'h0005);
    load(8'h30, 8'hEE);
    spi_bits(8'h77, 8, rx);
    spi_bits(8'hFF, 5, rx);
    spi_end();
    load(8'h31, 8'hCC);
    spi_hdr(8'h03, 16'h0005);
    spi_bits(8'h00, 8, rx);
    chk("t5_mem5", 32'(rx), 32'h77);
    spi_bits(8'h00, 8, rx);
    chk("t5_mem6", 32'(rx), 32'h66);
    spi_end();
    spi_hdr(8'h03, 16'h0030);
    spi_bits(8'h00, 8, rx);
    chk("t5_ld_busy_ignored", 32'(rx), 32'h99);
    spi_bits(8'h00, 8, rx);
    chk("t5_ld_idle_taken", 32'(rx), 32'hCC);
    spi_end();

    // 6: reset pulse in the middle of the address phase
    spi_cs_n = 1'b0;
    tick(4);
    spi_bits(8'h03, 8, rx);
    spi_bits(8'h00, 4, rx);
    rst_n = 1'b0;
    tick(1);
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_miso", 32'(spi_miso), 32'h0);
    chk("t6_last_cmd", 32'(last_cmd), 32'h00);
    chk("t6_cmd_err", 32'(cmd_err), 32'h0);
    rst_n = 1'b1;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    tick(4);
    spi_hdr(8'h03, 16'h0010);
    spi_bits(8'h00, 8, rx);
    chk("t6_read_after_reset", 32'(rx), 32'hA5);
    spi_end();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
